// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate type for the display blocks.
package vga_timing_pkg;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;

    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    localparam int COORD_W = 10;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster bundle driven by the timing generator and consumed by sprite/palette blocks.
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic   vga_clk;
    logic   hs;
    logic   vs;
    logic   blank;
    logic   frame_start;
    coord_t DrawX;
    coord_t DrawY;

    modport master (
        output vga_clk, hs, vs, blank, frame_start, DrawX, DrawY
    );

    modport slave (
        input vga_clk, hs, vs, blank, frame_start, DrawX, DrawY
    );

endinterface

// File: rtl/wrap_counter.sv
// Modulo-N counter with enable; exposes its next value so callers can register
// decodes that line up with the counter itself.
module wrap_counter #(
    parameter int N = 800,
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         wrap
);

    assign wrap = (count == W'(N - 1));

    always_comb begin
        count_next = count;
        if (en) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: halves Clk into vga_clk and produces DrawX/DrawY with
// hs/vs/blank/frame_start all registered on the vga_clk rising edge.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic         Clk,
    input  logic         Reset,
    vga_timing_if.master vga
);

    localparam int LINE_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int FRAME_LINES = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (LINE_TOTAL > (1 << COORD_W) || FRAME_LINES > (1 << COORD_W)) begin : g_total_check
        $error("vga_timing_gen: H/V totals do not fit in coord_t");
    end

    localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
    localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
    localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam coord_t H_VIS    = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS    = coord_t'(V_VISIBLE);

    logic   vga_clk_q;
    logic   pix_adv;
    logic   hs_q;
    logic   vs_q;
    logic   blank_q;
    logic   frame_start_q;
    coord_t x_cnt;
    coord_t x_next;
    coord_t y_cnt;
    coord_t y_next;
    logic   x_wrap;
    logic   y_wrap;

    // Pixels advance on the Clk edge where vga_clk rises.
    assign pix_adv = ~vga_clk_q;

    wrap_counter #(.N(LINE_TOTAL), .W(COORD_W)) u_hcount (
        .clk        (Clk),
        .reset      (Reset),
        .en         (pix_adv),
        .count      (x_cnt),
        .count_next (x_next),
        .wrap       (x_wrap)
    );

    wrap_counter #(.N(FRAME_LINES), .W(COORD_W)) u_vcount (
        .clk        (Clk),
        .reset      (Reset),
        .en         (pix_adv & x_wrap),
        .count      (y_cnt),
        .count_next (y_next),
        .wrap       (y_wrap)
    );

    // Decodes use next counter values so they describe the same pixel as DrawX/DrawY.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vga_clk_q     <= 1'b0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            vga_clk_q <= ~vga_clk_q;
            if (pix_adv) begin
                hs_q          <= !((x_next >= HS_START) && (x_next < HS_END));
                vs_q          <= !((y_next >= VS_START) && (y_next < VS_END));
                blank_q       <= (x_next < H_VIS) && (y_next < V_VIS);
                frame_start_q <= x_wrap & y_wrap;
            end
        end
    end

    assign vga.vga_clk     = vga_clk_q;
    assign vga.hs          = hs_q;
    assign vga.vs          = vs_q;
    assign vga.blank       = blank_q;
    assign vga.frame_start = frame_start_q;
    assign vga.DrawX       = x_cnt;
    assign vga.DrawY       = y_cnt;

endmodule
